// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for two load/store requesters in front of data_mem.
// Issues one single-cycle memread/memwrite strobe per transaction, waits out clk_stall, returns data.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, handshake latches the request
// ISSUE | one cycle with mem_memread or mem_memwrite asserted
// WAIT  | strobes low; waiting for data_mem to finish (stall ignored for SETTLE cycles)
// RESP  | one-cycle response pulse on the granted port
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SETTLE    = 1,
    parameter int MAX_STALL = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_write,
    input  logic [3:0]        req0_sign_mask,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_write,
    input  logic [3:0]        req1_sign_mask,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [3:0]        mem_sign_mask,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_clk_stall,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);
    localparam logic [7:0] MAX_C    = 8'(MAX_STALL);

    state_t            state;
    logic              last_grant;
    logic              cur_port;
    logic              cur_write;
    logic [7:0]        stall_cnt;
    logic              grant;
    logic              accept;
    logic              wait_done;
    logic              wait_abort;
    logic [DATA_W-1:0] wait_data;

    // Tie goes to the port that did not win last; a lone requester always wins.
    assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) && !reset && !grant && req0_valid;
    assign req1_ready = (state == IDLE) && !reset && grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    assign wait_done  = (stall_cnt >= SETTLE_C) && !mem_clk_stall;
    assign wait_abort = !wait_done && (stall_cnt >= MAX_C);
    assign wait_data  = (cur_write || wait_abort) ? '0 : mem_read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            cur_port       <= 1'b0;
            cur_write      <= 1'b0;
            stall_cnt      <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp0_rdata     <= '0;
            rsp1_rdata     <= '0;
            timeout_err    <= 1'b0;
        end else begin
            mem_memwrite <= 1'b0;
            mem_memread  <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr       <= grant ? req1_addr      : req0_addr;
                        mem_write_data <= grant ? req1_wdata     : req0_wdata;
                        mem_sign_mask  <= grant ? req1_sign_mask : req0_sign_mask;
                        cur_write      <= grant ? req1_write     : req0_write;
                        mem_memwrite   <= grant ? req1_write     : req0_write;
                        mem_memread    <= grant ? !req1_write    : !req0_write;
                        cur_port       <= grant;
                        last_grant     <= grant;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    stall_cnt <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wait_done || wait_abort) begin
                        if (cur_port) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= wait_data;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= wait_data;
                        end
                        if (wait_abort) timeout_err <= 1'b1;
                        state <= RESP;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte-addressed data_mem model with programmable stall,
// scoreboard of expected responses, per-scenario tasks.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_write, rsp0_valid;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic [3:0]  req0_sign_mask;
    logic        req1_valid, req1_ready, req1_write, rsp1_valid;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [3:0]  req1_sign_mask;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread, mem_clk_stall, timeout_err;
    logic [3:0]  mem_sign_mask;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .SETTLE(1), .MAX_STALL(255)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_write(req0_write), .req0_sign_mask(req0_sign_mask),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_write(req1_write), .req1_sign_mask(req1_sign_mask),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
        .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall), .timeout_err(timeout_err)
    );

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    exp_t      sb[$];
    bit        grant_log[$];
    int        checks = 0;
    int        failures = 0;
    int        cyc = 0;
    int        rsp_cyc = 0;
    int        strobe_cyc = 0;
    int        strobe_cnt = 0;
    bit        last_strobe_wr = 0;
    int        stall_len = 0;
    int        pend = 0;
    int        rem = 0;
    bit        model_clr = 0;
    bit [7:0]  mem [int unsigned];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] v;
        v = {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
        case (m[2:0])
            3'b001:  v = m[3] ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
            3'b011:  v = m[3] ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    // data_mem stand-in: stall rises two cycles after the strobe and lasts stall_len cycles.
    always @(negedge clk) begin
        if (model_clr) begin
            pend = 0;
            rem = 0;
            mem_clk_stall = 1'b0;
        end else begin
            if (rem > 0) begin
                rem--;
                if (rem == 0) mem_clk_stall = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0 && stall_len > 0) begin
                    mem_clk_stall = 1'b1;
                    rem = stall_len;
                end
            end
            if (mem_memwrite) begin
                case (mem_sign_mask[2:0])
                    3'b001: mem[mem_addr] = mem_write_data[7:0];
                    3'b011: for (int i = 0; i < 2; i++) mem[mem_addr + i] = mem_write_data[8*i +: 8];
                    default: for (int i = 0; i < 4; i++) mem[mem_addr + i] = mem_write_data[8*i +: 8];
                endcase
            end
            if (mem_memread) mem_read_data = mem_rd(mem_addr, mem_sign_mask);
            if (mem_memwrite || mem_memread) begin
                pend = 2;
                strobe_cyc = cyc;
                strobe_cnt++;
                last_strobe_wr = mem_memwrite;
            end
        end
    end

    // Response monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_ready && req1_ready) begin
                checks++;
                failures++;
                $display("FAIL ready_exclusive: both ready=1, required at most one");
            end
            if (rsp0_valid || rsp1_valid) begin
                rsp_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: rsp0=%0b rsp1=%0b with empty scoreboard", rsp0_valid, rsp1_valid);
                end else begin
                    exp_t e;
                    logic [31:0] got;
                    e = sb.pop_front();
                    got = e.port ? rsp1_rdata : rsp0_rdata;
                    if ((e.port ? !rsp1_valid || rsp0_valid : !rsp0_valid || rsp1_valid) || got !== e.rdata) begin
                        failures++;
                        $display("FAIL rsp_port%0d: rsp0=%0b rsp1=%0b rdata=%h, required port%0d rdata=%h",
                                 e.port, rsp0_valid, rsp1_valid, got, e.port, e.rdata);
                    end
                end
            end
        end
    end

    task automatic drive_port(input bit p, input bit v, input logic [31:0] a, input logic [31:0] wd,
                              input bit w, input logic [3:0] m);
        if (p) begin
            req1_valid = v; req1_addr = a; req1_wdata = wd; req1_write = w; req1_sign_mask = m;
        end else begin
            req0_valid = v; req0_addr = a; req0_wdata = wd; req0_write = w; req0_sign_mask = m;
        end
    endtask

    // Called just after a falling edge; returns after the handshake edge with valid dropped.
    task automatic send(input bit p, input logic [31:0] a, input logic [31:0] wd, input bit w,
                        input logic [3:0] m, input logic [31:0] exp_rd, output int c0);
        exp_t e;
        c0 = -1;
        drive_port(p, 1'b1, a, wd, w, m);
        #1;
        for (int n = 0; n < 2000; n++) begin
            if (p ? req1_ready : req0_ready) begin
                e.port = p;
                e.rdata = exp_rd;
                sb.push_back(e);
                grant_log.push_back(p);
                c0 = cyc;
                @(negedge clk);
                drive_port(p, 1'b0, a, wd, w, m);
                return;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL handshake_port%0d: no ready within 2000 cycles", p);
        drive_port(p, 1'b0, a, wd, w, m);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 1000; n++) begin
            if (sb.size() == 0) begin
                @(negedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL drain: %0d responses still pending after 1000 cycles", sb.size());
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_port(0, 1'b1, 32'h400, 32'h0, 1'b0, 4'b0001);
        drive_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0000);
        mem_read_data = 32'h0;
        mem_clk_stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
        checks++;
        if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: rd=%b wr=%b rsp0=%b rsp1=%b, required all 0",
                     mem_memread, mem_memwrite, rsp0_valid, rsp1_valid);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_sign_mask !== 4'h0 || timeout_err !== 1'b0 || rsp0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs: addr=%h mask=%h terr=%b rdata0=%h, required zeros",
                     mem_addr, mem_sign_mask, timeout_err, rsp0_rdata);
        end
        req0_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_port0_store();
        int c0;
        int s0;
        stall_len = 0;
        s0 = strobe_cnt;
        send(0, 32'h400, 32'hAAA, 1'b1, 4'b0001, 32'h0, c0);
        wait_idle();
        checks++;
        if (strobe_cnt - s0 != 1 || last_strobe_wr !== 1'b1 || strobe_cyc != c0 + 1) begin
            failures++;
            $display("FAIL store_strobe: count=%0d write=%b at cycle +%0d, required 1 write at +1",
                     strobe_cnt - s0, last_strobe_wr, strobe_cyc - c0);
        end
        checks++;
        if (rsp_cyc != c0 + 4) begin
            failures++;
            $display("FAIL store_latency: rsp at +%0d, required +4", rsp_cyc - c0);
        end
    endtask

    task automatic test_port0_loads();
        int c0;
        send(0, 32'h400, 32'h0, 1'b0, 4'b1001, 32'hFFFFFFAA, c0);
        send(0, 32'h400, 32'h0, 1'b0, 4'b0001, 32'h000000AA, c0);
        wait_idle();
        checks++;
        if (rsp_cyc != c0 + 4 || last_strobe_wr !== 1'b0) begin
            failures++;
            $display("FAIL load_latency: rsp at +%0d write=%b, required +4 read", rsp_cyc - c0, last_strobe_wr);
        end
    endtask

    task automatic test_port1();
        int c0;
        send(1, 32'h100, 32'h0002AAAA, 1'b1, 4'b0011, 32'h0, c0);
        send(1, 32'h100, 32'h0, 1'b0, 4'b1011, 32'hFFFFAAAA, c0);
        send(1, 32'h100, 32'h0, 1'b0, 4'b0011, 32'h0000AAAA, c0);
        send(1, 32'h40, 32'hAAAAAAAA, 1'b1, 4'b0111, 32'h0, c0);
        send(1, 32'h40, 32'h0, 1'b0, 4'b0111, 32'hAAAAAAAA, c0);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int ca, cb;
        bit exp_order [4] = '{0, 1, 0, 1};
        grant_log.delete();
        fork
            begin
                send(0, 32'h400, 32'h0, 1'b0, 4'b0001, 32'h000000AA, ca);
                send(0, 32'h100, 32'h0, 1'b0, 4'b0011, 32'h0000AAAA, ca);
            end
            begin
                send(1, 32'h40, 32'h0, 1'b0, 4'b0111, 32'hAAAAAAAA, cb);
                send(1, 32'h400, 32'h0, 1'b0, 4'b1001, 32'hFFFFFFAA, cb);
            end
        join
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_log.size() <= i || grant_log[i] !== exp_order[i]) begin
                failures++;
                $display("FAIL grant_order[%0d]: got %0d, required %0d",
                         i, (grant_log.size() > i) ? int'(grant_log[i]) : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_stall();
        int c0;
        int bad = 0;
        int lat = -1;
        stall_len = 10;
        send(0, 32'h40, 32'h0, 1'b0, 4'b0111, 32'hAAAAAAAA, c0);
        for (int n = 0; n < 100; n++) begin
            if (rsp0_valid) begin
                lat = cyc - c0;
                break;
            end
            if (mem_addr !== 32'h40 || mem_sign_mask !== 4'b0111) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold: addr/mask changed in %0d cycles, required 0", bad);
        end
        checks++;
        if (lat != 14) begin
            failures++;
            $display("FAIL stall_latency: rsp at +%0d, required +14", lat);
        end
        wait_idle();
        stall_len = 0;
    endtask

    task automatic test_timeout();
        int c0;
        int lat = -1;
        stall_len = 300;
        send(1, 32'h100, 32'h0, 1'b0, 4'b0011, 32'h0, c0);
        for (int n = 0; n < 400; n++) begin
            if (rsp1_valid) begin
                lat = cyc - c0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat != 258) begin
            failures++;
            $display("FAIL timeout_latency: rsp at +%0d, required +258", lat);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag: timeout_err=%b, required 1", timeout_err);
        end
        for (int n = 0; n < 100 && mem_clk_stall; n++) @(negedge clk);
        stall_len = 0;
        send(0, 32'h400, 32'h0, 1'b0, 4'b0001, 32'h000000AA, c0);
        wait_idle();
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int ca, cb;
        bit exp_order [2] = '{0, 1};
        stall_len = 20;
        send(0, 32'h400, 32'h0, 1'b0, 4'b0001, 32'h000000AA, ca);
        repeat (4) @(negedge clk);
        drive_port(1, 1'b1, 32'h40, 32'h0, 1'b0, 4'b0111);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: rd=%b wr=%b rsp0=%b rsp1=%b rdy0=%b rdy1=%b, required all 0",
                     mem_memread, mem_memwrite, rsp0_valid, rsp1_valid, req0_ready, req1_ready);
        end
        checks++;
        if (timeout_err !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_regs: terr=%b addr=%h, required 0 0", timeout_err, mem_addr);
        end
        sb.delete();
        model_clr = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clr = 1'b0;
        stall_len = 0;
        grant_log.delete();
        fork
            send(0, 32'h100, 32'h0, 1'b0, 4'b1011, 32'hFFFFAAAA, ca);
            send(1, 32'h40, 32'h0, 1'b0, 4'b0111, 32'hAAAAAAAA, cb);
        join
        wait_idle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_log.size() <= i || grant_log[i] !== exp_order[i]) begin
                failures++;
                $display("FAIL post_reset_grant[%0d]: got %0d, required %0d",
                         i, (grant_log.size() > i) ? int'(grant_log[i]) : -1, exp_order[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_port0_store();
        test_port0_loads();
        test_port1();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
